async_rr_merge: RTL and testbench

//  Round-robin merge arbiter that shares one async_operator input channel among NUM_IN upstream

---
 rtl/async_rr_merge.sv | 144 ++++++++++++++
 tb/tb_async_rr_merge.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_rr_merge.sv
// Round-robin merge of NUM_IN req/ack producers into one FIFO-buffered, source-tagged stream.
// Define ARB_TIMEOUT_EN to let a grant rotate after TIMEOUT cycles without an ack.
module async_rr_merge #(
    parameter int data_width = 32,
    parameter int NUM_IN     = 4,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 8,
    parameter int ID_W       = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [NUM_IN-1:0]            req_l,
    input  logic [NUM_IN-1:0]            ack_l,
    input  logic [data_width*NUM_IN-1:0] din,
    input  logic                         req_r,
    output logic                         ack_r,
    output logic [data_width-1:0]        dout,
    output logic [ID_W-1:0]              src_id
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_IN - 1);

    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("async_rr_merge: NUM_IN out of range");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("async_rr_merge: DEPTH must be a power of 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("async_rr_merge: TIMEOUT must be >= 2");
    end

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state;
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       g;
    logic [ID_W-1:0]       g_next;
    logic [AW-1:0]         rd;
    logic [AW-1:0]         wr;
    logic [CW-1:0]         count;
    logic [data_width-1:0] mem_d [DEPTH];
    logic [ID_W-1:0]       mem_t [DEPTH];
    logic [data_width-1:0] slice;
    logic                  pending;
    logic                  free;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // An open grant reserves a slot, so a push never finds the FIFO full.
    assign pending = (state == WAIT);
    assign free    = (count + CW'(pending)) < DEPTH_C;
    assign push    = (state == WAIT) && ack_l[g];
    assign pop     = (count != '0) && req_r && !ack_r;
    assign g_next  = (g == LAST) ? '0 : g + 1'b1;
    assign slice   = din[int'(g)*data_width +: data_width];

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo <= '0;
        end else if (state == IDLE) begin
            tmo <= '0;
        end else if (!ack_l[g]) begin
            tmo <= tmo + 1'b1;
        end
    end

    // A same-cycle ack beats the timeout.
    assign drop = (state == WAIT) && !ack_l[g] && (tmo == TMO_LAST);
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            req_l <= '0;
            ptr   <= '0;
            g     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (free) begin
                        req_l <= NUM_IN'(1) << ptr;
                        g     <= ptr;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (push || drop) begin
                        req_l <= '0;
                        ptr   <= g_next;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_d[wr] <= slice;
            mem_t[wr] <= g;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd     <= '0;
            wr     <= '0;
            count  <= '0;
            ack_r  <= 1'b0;
            dout   <= '0;
            src_id <= '0;
        end else begin
            ack_r <= pop;
            if (push) begin
                wr <= wr + 1'b1;
            end
            if (pop) begin
                rd     <= rd + 1'b1;
                dout   <= mem_d[rd];
                src_id <= mem_t[rd];
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_async_rr_merge.sv
// Directed bench for async_rr_merge: modelled producers, a consumer monitor,
// one task per scenario.
module tb_async_rr_merge;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int D  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_l;
    logic [N-1:0]    ack_l = '0;
    logic [DW*N-1:0] din;
    logic            req_r = 1'b0;
    logic            ack_r;
    logic [DW-1:0]   dout;
    logic [1:0]      src_id;

    int errors = 0;
    int checks = 0;

    int           vals [N];
    int           init [N];
    logic [N-1:0] en = '0;
    int           stall_pct = 0;
    logic         rnd_cons = 1'b0;
    int           got_d [$];
    int           got_id [$];

    async_rr_merge #(
        .data_width(DW),
        .NUM_IN(N),
        .DEPTH(D),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_l(req_l),
        .ack_l(ack_l),
        .din(din),
        .req_r(req_r),
        .ack_r(ack_r),
        .dout(dout),
        .src_id(src_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        din = '0;
        for (int i = 0; i < N; i++) din[i*DW +: DW] = vals[i];
    end

    // Producer i: an ack seen at the last edge consumed its word.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (ack_l[i]) vals[i] = vals[i] + 1;
            ack_l[i] = req_l[i] && en[i] &&
                       ($urandom_range(99) >= stall_pct);
        end
        if (rnd_cons) req_r = ($urandom_range(99) >= 30);
    end

    always @(posedge clk) begin
        #1;
        if (ack_r) begin
            got_d.push_back(int'(dout));
            got_id.push_back(int'(src_id));
        end
    end

    task automatic do_reset(input int base);
        rst = 1'b0;
        req_r = 1'b0;
        rnd_cons = 1'b0;
        en = '0;
        stall_pct = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            vals[i] = base * i;
            init[i] = base * i;
        end
        got_d.delete();
        got_id.delete();
        en = '1;
        rst = 1'b1;
    endtask

    task automatic wait_words(input int n, input int budget, input string nm);
        for (int c = 0; c < budget && got_d.size() < n; c++) @(negedge clk);
        checks++;
        if (got_d.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d words, required %0d", nm, got_d.size(), n);
        end
    endtask

    task automatic check_rr(input int n, input string nm);
        for (int k = 0; k < n && k < got_d.size(); k++) begin
            checks++;
            if (got_id[k] !== k % 4 || got_d[k] !== 100 * (k % 4) + k / 4) begin
                errors++;
                $display("FAIL %s[%0d]: id=%0d d=%0d, required id=%0d d=%0d",
                         nm, k, got_id[k], got_d[k], k % 4, 100 * (k % 4) + k / 4);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        req_r = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_l !== '0 || ack_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: req_l=%b ack_r=%b, required 0 0", req_l, ack_r);
        end
        checks++;
        if (dout !== '0 || src_id !== '0) begin
            errors++;
            $display("FAIL reset_out: dout=%0d src_id=%0d, required 0 0", dout, src_id);
        end
        req_r = 1'b0;
    endtask

    task automatic test_round_robin;
        do_reset(100);
        req_r = 1'b1;
        wait_words(12, 300, "rr_count");
        check_rr(12, "rr");
        req_r = 1'b0;
    endtask

    task automatic test_full;
        int cap;
        do_reset(100);
        repeat (50) @(negedge clk);
        cap = 0;
        for (int i = 0; i < N; i++) cap += vals[i] - init[i];
        checks++;
        if (cap !== D) begin
            errors++;
            $display("FAIL full_captured: %0d, required %0d", cap, D);
        end
        checks++;
        if (req_l !== '0 || got_d.size() !== 0) begin
            errors++;
            $display("FAIL full_idle: req_l=%b out=%0d, required 0000 0", req_l, got_d.size());
        end
        req_r = 1'b1;
        wait_words(12, 300, "full_count");
        check_rr(12, "full");
        req_r = 1'b0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        int hi;
        int xd [6];
        int xi [6];
        xd = '{0, 100, 300, 1, 101, 301};
        xi = '{0, 1, 3, 0, 1, 3};
        do_reset(100);
        en[2] = 1'b0;
        req_r = 1'b1;
        for (int c = 0; c < 100 && req_l !== 4'b0100; c++) @(negedge clk);
        hi = 0;
        while (req_l === 4'b0100 && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        checks++;
        if (hi !== 8) begin
            errors++;
            $display("FAIL tmo_len: req_l[2] high %0d cycles, required 8", hi);
        end
        for (int c = 0; c < 10 && req_l === '0; c++) @(negedge clk);
        checks++;
        if (req_l !== 4'b1000) begin
            errors++;
            $display("FAIL tmo_next: req_l=%b, required 1000", req_l);
        end
        wait_words(6, 200, "tmo_count");
        for (int k = 0; k < 6 && k < got_d.size(); k++) begin
            checks++;
            if (got_id[k] !== xi[k] || got_d[k] !== xd[k]) begin
                errors++;
                $display("FAIL tmo[%0d]: id=%0d d=%0d, required id=%0d d=%0d",
                         k, got_id[k], got_d[k], xi[k], xd[k]);
            end
        end
        req_r = 1'b0;
    endtask
`else
    task automatic test_stall;
        int seen;
        do_reset(100);
        en[2] = 1'b0;
        req_r = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (req_l !== 4'b0100) begin
            errors++;
            $display("FAIL stall_req: req_l=%b, required 0100", req_l);
        end
        checks++;
        if (got_d.size() !== 2 || got_id[0] !== 0 || got_id[1] !== 1 ||
            got_d[0] !== 0 || got_d[1] !== 100) begin
            errors++;
            $display("FAIL stall_words: n=%0d, required 2 words (0,100) from 0,1", got_d.size());
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack_r) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL stall_ack: ack_r high %0d cycles, required 0", seen);
        end
        req_r = 1'b0;
    endtask
`endif

    task automatic test_reset_mid;
        do_reset(100);
        en[3] = 1'b0;
        for (int c = 0; c < 100 && req_l !== 4'b1000; c++) @(negedge clk);
        checks++;
        if (req_l !== 4'b1000) begin
            errors++;
            $display("FAIL mid_setup: req_l=%b, required 1000", req_l);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_l !== '0 || ack_r !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: req_l=%b ack_r=%b, required 0 0", req_l, ack_r);
        end
        rst = 1'b1;
        en = '1;
        got_d.delete();
        got_id.delete();
        req_r = 1'b1;
        wait_words(2, 100, "mid_count");
        checks++;
        if (got_d.size() < 2 || got_id[0] !== 0 || got_d[0] !== 1 ||
            got_id[1] !== 1 || got_d[1] !== 101) begin
            errors++;
            $display("FAIL mid_first: n=%0d, required (0:1) then (1:101)", got_d.size());
        end
        req_r = 1'b0;
    endtask

    task automatic test_stress;
        int exp [N];
        int pushed;
        do_reset(10000);
        stall_pct = 30;
        rnd_cons = 1'b1;
        for (int i = 0; i < N; i++) exp[i] = init[i];
        for (int c = 0; c < 20000 && got_d.size() < 400; c++) @(negedge clk);
        en = '0;
        rnd_cons = 1'b0;
        req_r = 1'b1;
        repeat (30) @(negedge clk);
        pushed = 0;
        for (int i = 0; i < N; i++) pushed += vals[i] - init[i];
        checks++;
        if (got_d.size() < 400 || got_d.size() !== pushed) begin
            errors++;
            $display("FAIL stress_total: consumed=%0d pushed=%0d, required equal and >=400",
                     got_d.size(), pushed);
        end
        for (int k = 0; k < got_d.size(); k++) begin
            checks++;
            if (got_id[k] < 0 || got_id[k] >= N) begin
                errors++;
                $display("FAIL stress_id[%0d]: %0d, required < %0d", k, got_id[k], N);
            end else if (got_d[k] !== exp[got_id[k]]) begin
                errors++;
                $display("FAIL stress_seq[%0d]: src %0d d=%0d, required %0d",
                         k, got_id[k], got_d[k], exp[got_id[k]]);
                exp[got_id[k]] = got_d[k] + 1;
            end else begin
                exp[got_id[k]]++;
            end
        end
        req_r = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) vals[i] = 0;
        test_reset;
        test_round_robin;
        test_full;
`ifdef ARB_TIMEOUT_EN
        test_timeout;
`else
        test_stall;
`endif
        test_reset_mid;
        test_stress;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
